// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-handling logic: refill FSM states,
// default line geometry and the word-offset helper used to form addresses.
package cache_pkg;

  // Default line geometry; instances may override LINE_WORDS per cache.
  localparam int DEF_LINE_WORDS = 4;
  localparam int WORD_IDX_W     = $clog2(DEF_LINE_WORDS);
  localparam int BYTE_OFF_W     = WORD_IDX_W + 2;

  // Refill controller states. IDLE is encoded as zero so that a reset
  // state register reads back as all-zero on the debug output.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_COMMIT    = 2'd3
  } refill_state_e;

  // Byte offset of a 32-bit word inside a line, added to a line base.
  function automatic logic [31:0] word_offset(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/cache_refill_controller.sv
// Miss-handling engine: writes a dirty victim line back word by word, then
// fetches the missing line into the victim way and marks it valid/clean.
// state_o exposes the FSM state for debug and checker binding.
//
// Handshake: mem_req_o is held high with a stable address/write flag until
// the memory answers with mem_ready_i in the same cycle; that cycle is the
// transfer. mem_ready_i while mem_req_o is low has no effect.

`ifndef CACHE_E
`define CACHE_E 4
`endif

module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int SET_SIZE   = `CACHE_E,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          miss_i,
  input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
  input  logic [SET_SIZE-1:0]           victim_line_i,
  input  logic                          victim_dirty_i,
  input  logic [ADDR_WIDTH-1:0]         victim_addr_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [31:0]                   mem_rdata_i,
  output logic [SET_SIZE-1:0]           line_sel_o,
  output logic [$clog2(LINE_WORDS)-1:0] line_word_o,
  input  logic [31:0]                   line_rdata_i,
  output logic                          line_we_o,
  output logic [31:0]                   line_wdata_o,
  output logic                          set_valid_o,
  output logic [1:0]                    state_o
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

  refill_state_e         state;
  logic [IDX_W-1:0]      word_cnt;
  logic [ADDR_WIDTH-1:0] miss_base;
  logic [ADDR_WIDTH-1:0] victim_base;
  logic [SET_SIZE-1:0]   victim_sel;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] word_off;

  assign last_word = (word_cnt == LAST_WORD);
  assign word_off  = ADDR_WIDTH'(word_offset(32'(word_cnt)));

  // FSM, word counter and request latches; the counter wraps naturally at
  // the end of the write-back so the fetch restarts at word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      miss_base   <= '0;
      victim_base <= '0;
      victim_sel  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_i) begin
            miss_base   <= miss_addr_i & LINE_MASK;
            victim_base <= victim_addr_i;
            victim_sel  <= victim_line_i;
            word_cnt    <= '0;
            state       <= victim_dirty_i ? ST_WRITEBACK : ST_FETCH;
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready_i) begin
            word_cnt <= word_cnt + IDX_W'(1);
            if (last_word) begin
              word_cnt <= '0;
              state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (mem_ready_i) begin
            word_cnt <= word_cnt + IDX_W'(1);
            if (last_word) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Memory- and line-side outputs decoded from state and latched registers;
  // everything is forced to zero in IDLE so reset drives all outputs low.
  always_comb begin
    busy_o       = (state != ST_IDLE);
    done_o       = (state == ST_COMMIT);
    set_valid_o  = (state == ST_COMMIT);
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    line_sel_o   = '0;
    line_word_o  = '0;
    line_we_o    = 1'b0;
    line_wdata_o = '0;
    state_o      = state;
    if (state != ST_IDLE) line_sel_o = victim_sel;
    if (state == ST_WRITEBACK) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = victim_base + word_off;
      mem_wdata_o = line_rdata_i;
      line_word_o = word_cnt;
    end
    if (state == ST_FETCH) begin
      mem_req_o    = 1'b1;
      mem_addr_o   = miss_base + word_off;
      line_word_o  = word_cnt;
      line_we_o    = mem_ready_i;
      line_wdata_o = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Randomized scoreboard bench for cache_refill_controller (4 ways, 4 words).
module tb_cache_refill_controller;

  localparam int SET_SIZE = 4;
  localparam int LW       = 4;
  localparam int AW       = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                miss_i = 1'b0;
  logic [AW-1:0]       miss_addr_i = '0;
  logic [SET_SIZE-1:0] victim_line_i = '0;
  logic                victim_dirty_i = 1'b0;
  logic [AW-1:0]       victim_addr_i = '0;
  logic                busy_o, done_o, mem_req_o, mem_we_o;
  logic [AW-1:0]       mem_addr_o;
  logic [31:0]         mem_wdata_o;
  logic                mem_ready_i = 1'b0;
  logic [31:0]         mem_rdata_i = '0;
  logic [SET_SIZE-1:0] line_sel_o;
  logic [1:0]          line_word_o;
  logic [31:0]         line_rdata_i;
  logic                line_we_o;
  logic [31:0]         line_wdata_o;
  logic                set_valid_o;
  logic [1:0]          state_o;

  cache_refill_controller #(
    .SET_SIZE(SET_SIZE), .LINE_WORDS(LW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .victim_line_i(victim_line_i), .victim_dirty_i(victim_dirty_i),
    .victim_addr_i(victim_addr_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .line_sel_o(line_sel_o), .line_word_o(line_word_o), .line_rdata_i(line_rdata_i),
    .line_we_o(line_we_o), .line_wdata_o(line_wdata_o), .set_valid_o(set_valid_o),
    .state_o(state_o)
  );

  // ---------------- reference state ----------------
  logic [31:0] arr [SET_SIZE][LW];   // line array contents as the bench knows them
  logic [64:0] exp_q[$];             // {we, addr, wdata} memory transfers
  logic [37:0] exp_lq[$];            // {way one-hot, word, data} line writes
  int n_vec = 0;
  int n_err = 0;
  int sv_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit zero_wait = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00C3;
  endfunction

  function automatic logic [SET_SIZE-1:0] onehot(input int way);
    logic [SET_SIZE-1:0] v;
    v = '0;
    v[way] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Combinational line-array read port seen by the DUT.
  always_comb begin
    line_rdata_i = '0;
    for (int i = 0; i < SET_SIZE; i++)
      if (line_sel_o[i]) line_rdata_i = arr[i][line_word_o];
  end

  // Upstream must present a one-hot victim with each request.
  always @(negedge clk) begin
    if (rst_n && miss_i && !busy_o)
      assert ($onehot(victim_line_i)) else $error("victim_line_i not one-hot: %b", victim_line_i);
  end

  // ---------------- memory responder ----------------
  initial begin
    int wait_left;
    wait_left = -1;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o) begin
        if (wait_left < 0) wait_left = zero_wait ? 0 : int'($urandom_range(0, 3));
        if (wait_left == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem_we_o ? $urandom : mem_word(mem_addr_o);
          wait_left = -1;
        end else begin
          mem_ready_i = 1'b0;
          mem_rdata_i = $urandom;
          wait_left--;
        end
      end else begin
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        wait_left = -1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [64:0] e;
    logic [37:0] le;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (prev_wait && mem_req_o) check("addr_stable", 128'(mem_addr_o), 128'(prev_addr));
      if (mem_req_o && mem_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 128'(mem_addr_o), 128'hFFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("mem_we", 128'(mem_we_o), 128'(e[64]));
          check("mem_addr", 128'(mem_addr_o), 128'(e[63:32]));
          if (e[64]) check("mem_wdata", 128'(mem_wdata_o), 128'(e[31:0]));
        end
      end
      if (line_we_o) begin
        if (exp_lq.size() == 0) begin
          check("unexpected_line_we", 128'(line_word_o), 128'hFFFF_FFFF_FFFF);
        end else begin
          le = exp_lq.pop_front();
          check("line_write", 128'({line_sel_o, line_word_o, line_wdata_o}), 128'(le));
        end
      end
      if (set_valid_o) sv_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_wait = mem_req_o && !mem_ready_i;
      prev_addr = mem_addr_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o) return;
    end
    check("idle_timeout", 128'(busy_o), 128'(0));
  endtask

  task automatic push_expect(input logic [31:0] maddr, input int way,
                             input logic dirty, input logic [31:0] vaddr);
    logic [31:0] mb;
    mb = maddr & ~32'hF;
    if (dirty)
      for (int i = 0; i < LW; i++) exp_q.push_back({1'b1, vaddr + 32'(4 * i), arr[way][i]});
    for (int i = 0; i < LW; i++) begin
      exp_q.push_back({1'b0, mb + 32'(4 * i), 32'h0});
      exp_lq.push_back({onehot(way), 2'(i), mem_word(mb + 32'(4 * i))});
    end
  endtask

  task automatic drive_miss(input logic [31:0] maddr, input int way,
                            input logic dirty, input logic [31:0] vaddr);
    miss_i = 1'b1;
    miss_addr_i = maddr;
    victim_line_i = onehot(way);
    victim_dirty_i = dirty;
    victim_addr_i = vaddr;
  endtask

  task automatic wait_done(input int start_done, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_cnt != start_done) begin
        ok = 1'b1;
        return;
      end
    end
    check("done_timeout", 128'(done_cnt), 128'(start_done + 1));
  endtask

  task automatic finish_refill(input logic [31:0] maddr, input int way, input logic dirty,
                               input int accept_cyc, input int start_sv);
    logic [31:0] mb;
    mb = maddr & ~32'hF;
    if (zero_wait) check("done_latency", 128'(done_cyc - accept_cyc), 128'(dirty ? 2 * LW : LW));
    check("set_valid_once", 128'(sv_cnt - start_sv), 128'(1));
    check("xfers_complete", 128'(exp_q.size()), 128'(0));
    check("line_writes_complete", 128'(exp_lq.size()), 128'(0));
    exp_q.delete();
    exp_lq.delete();
    for (int i = 0; i < LW; i++) arr[way][i] = mem_word(mb + 32'(4 * i));
  endtask

  task automatic run_miss(input logic [31:0] maddr, input int way,
                          input logic dirty, input logic [31:0] vaddr);
    int start_done, start_sv, accept_cyc;
    bit ok;
    wait_idle();
    push_expect(maddr, way, dirty, vaddr);
    drive_miss(maddr, way, dirty, vaddr);
    start_done = done_cnt;
    start_sv = sv_cnt;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    check("busy_after_accept", 128'(busy_o), 128'(1));
    check("req_after_accept", 128'(mem_req_o), 128'(1));
    miss_i = 1'b0;
    wait_done(start_done, ok);
    if (ok) finish_refill(maddr, way, dirty, accept_cyc, start_sv);
  endtask

  // miss_i stays high across a refill while the address changes: the new
  // address must only be taken in the first IDLE cycle after COMMIT.
  task automatic hold_test(input logic [31:0] addr_a, input logic [31:0] addr_b, input int way);
    int start_done, start_sv, accept_a, accept_b, done_a;
    bit ok;
    wait_idle();
    push_expect(addr_a, way, 1'b0, 32'h0);
    drive_miss(addr_a, way, 1'b0, 32'h0);
    start_done = done_cnt;
    start_sv = sv_cnt;
    @(posedge clk);
    #1;
    accept_a = cyc;
    miss_addr_i = addr_b;
    wait_done(start_done, ok);
    if (!ok) return;
    done_a = done_cyc;
    finish_refill(addr_a, way, 1'b0, accept_a, start_sv);
    push_expect(addr_b, way, 1'b0, 32'h0);
    start_done = done_cnt;
    start_sv = sv_cnt;
    if (cyc == done_a) @(negedge clk);
    check("idle_after_done", 128'(busy_o), 128'(0));
    @(posedge clk);
    #1;
    accept_b = cyc;
    check("restart_gap", 128'(accept_b - done_a), 128'(2));
    check("second_accept_busy", 128'(busy_o), 128'(1));
    miss_i = 1'b0;
    wait_done(start_done, ok);
    if (ok) finish_refill(addr_b, way, 1'b0, accept_b, start_sv);
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, line_sel_o,
                 line_word_o, line_we_o, line_wdata_o, set_valid_o, state_o});
  endfunction

  // Reset lands during the second fetch word: outputs drop at once and the
  // aborted refill never signals completion.
  task automatic reset_test(input logic [31:0] maddr, input int way);
    int start_done, start_sv;
    bit hit;
    wait_idle();
    push_expect(maddr, way, 1'b0, 32'h0);
    drive_miss(maddr, way, 1'b0, 32'h0);
    start_done = done_cnt;
    start_sv = sv_cnt;
    @(posedge clk);
    #1;
    miss_i = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      if (mem_req_o && !mem_we_o && line_word_o == 2'd1) hit = 1'b1;
    end
    check("reached_second_word", 128'(hit), 128'(1));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 128'(0));
    repeat (3) @(negedge clk);
    check("abort_no_done", 128'(done_cnt), 128'(start_done));
    check("abort_no_set_valid", 128'(sv_cnt), 128'(start_sv));
    check("reset_held_outputs", all_outputs(), 128'(0));
    exp_q.delete();
    exp_lq.delete();
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ma, va;
    int way;
    logic dirty;
    for (int w = 0; w < SET_SIZE; w++)
      for (int i = 0; i < LW; i++) arr[w][i] = $urandom;
    #1;
    check("reset_outputs", all_outputs(), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    zero_wait = 1'b1;
    run_miss(32'h0000_1234, 1, 1'b0, 32'h0000_4440);
    for (int i = 0; i < LW; i++) arr[2][i] = 32'hA000_0000 + 32'(i);
    run_miss(32'h0000_5678, 2, 1'b1, 32'h0000_8000);

    zero_wait = 1'b0;
    for (int n = 0; n < 20; n++) begin
      ma = $urandom;
      va = $urandom & ~32'hF;
      way = int'($urandom_range(0, SET_SIZE - 1));
      dirty = 1'($urandom_range(0, 1));
      run_miss(ma, way, dirty, va);
    end

    zero_wait = 1'($urandom_range(0, 1));
    hold_test(32'h0000_2000, 32'h0000_3004, 3);

    zero_wait = 1'b1;
    reset_test(32'h0000_7710, 0);
    run_miss(32'h0000_9ABC, 0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
